// File: rtl/spi_reg_bridge_pkg.sv
// Shared types and constants for the SPI-to-register-bus bridge.
package spi_reg_bridge_pkg;

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned BIT_CNT_W     = 3;
  localparam int unsigned CMD_WRITE_BIT = 7;
  localparam logic [BYTE_W-1:0] ADDR_MASK = 8'h7F;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    LOAD,
    DATA,
    COMMIT
  } state_t;

  // Post-increment of the 7-bit register address, wrapping 0x7F -> 0x00.
  function automatic logic [BYTE_W-1:0] next_addr(input logic [BYTE_W-1:0] addr);
    return (addr + 8'd1) & ADDR_MASK;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Brings sck/cs_n/mosi into the clk_i domain and flags synchronised sck edges.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic nrst_i,
  input  logic sck,
  input  logic cs_n,
  input  logic mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_active,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sck_sr;
  logic [SYNC_STAGES-1:0] cs_sr;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic                   sck_prev;

  // Synchroniser chains plus registered edge/level outputs; cs_n resets inactive.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      sck_sr    <= '0;
      cs_sr     <= '1;
      mosi_sr   <= '0;
      sck_prev  <= 1'b0;
      sck_rise  <= 1'b0;
      sck_fall  <= 1'b0;
      cs_active <= 1'b0;
      mosi_s    <= 1'b0;
    end else begin
      sck_sr    <= {sck_sr[SYNC_STAGES-2:0], sck};
      cs_sr     <= {cs_sr[SYNC_STAGES-2:0], cs_n};
      mosi_sr   <= {mosi_sr[SYNC_STAGES-2:0], mosi};
      sck_prev  <= sck_sr[SYNC_STAGES-1];
      sck_rise  <= sck_sr[SYNC_STAGES-1] & ~sck_prev;
      sck_fall  <= ~sck_sr[SYNC_STAGES-1] & sck_prev;
      cs_active <= ~cs_sr[SYNC_STAGES-1];
      mosi_s    <= mosi_sr[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns command/data frames into byte-wide register
// writes and returns register contents on MISO, with address auto-increment.
module spi_reg_bridge
  import spi_reg_bridge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       nrst_i,
  input  logic       spi_sck_i,
  input  logic       spi_cs_n_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic [7:0] b_addr_o,
  output logic [7:0] b_data_o,
  output logic       b_write_o,
  input  logic [7:0] b_data_i
);

  logic sck_rise;
  logic sck_fall;
  logic cs_active;
  logic mosi_s;

  state_t               state, state_next;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_next;
  logic [BYTE_W-2:0]    rx_sr, rx_sr_next;
  logic [BYTE_W-1:0]    tx_sr, tx_sr_next;
  logic                 rw, rw_next;
  logic [BYTE_W-1:0]    addr_next;
  logic [BYTE_W-1:0]    data_next;
  logic                 write_next;
  logic [BYTE_W-1:0]    rx_byte;

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i    (clk_i),
    .nrst_i   (nrst_i),
    .sck      (spi_sck_i),
    .cs_n     (spi_cs_n_i),
    .mosi     (spi_mosi_i),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .cs_active(cs_active),
    .mosi_s   (mosi_s)
  );

  // Byte as it stands once the current mosi bit is shifted in.
  assign rx_byte    = {rx_sr, mosi_s};
  assign spi_miso_o = tx_sr[BYTE_W-1];

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      rw        <= 1'b0;
      b_addr_o  <= '0;
      b_data_o  <= '0;
      b_write_o <= 1'b0;
    end else begin
      state     <= state_next;
      bit_cnt   <= bit_cnt_next;
      rx_sr     <= rx_sr_next;
      tx_sr     <= tx_sr_next;
      rw        <= rw_next;
      b_addr_o  <= addr_next;
      b_data_o  <= data_next;
      b_write_o <= write_next;
    end
  end

  // Next-state and datapath updates; the write strobe is raised on entry to
  // COMMIT so it is high for exactly the COMMIT cycle.
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    rx_sr_next   = rx_sr;
    tx_sr_next   = tx_sr;
    rw_next      = rw;
    addr_next    = b_addr_o;
    data_next    = b_data_o;
    write_next   = 1'b0;

    unique case (state)
      IDLE: begin
        bit_cnt_next = '0;
        tx_sr_next   = '0;
        if (cs_active) state_next = CMD;
      end
      CMD: begin
        if (!cs_active) begin
          state_next = IDLE;
        end else if (sck_rise) begin
          rx_sr_next   = rx_byte[BYTE_W-2:0];
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            addr_next  = rx_byte & ADDR_MASK;
            rw_next    = rx_byte[CMD_WRITE_BIT];
            state_next = rx_byte[CMD_WRITE_BIT] ? DATA : LOAD;
          end
        end
      end
      LOAD: begin
        if (!cs_active) begin
          state_next = IDLE;
        end else begin
          tx_sr_next = b_data_i;
          state_next = DATA;
        end
      end
      DATA: begin
        if (!cs_active) begin
          state_next = IDLE;
        end else if (sck_rise) begin
          rx_sr_next   = rx_byte[BYTE_W-2:0];
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_next = COMMIT;
            if (rw) begin
              data_next  = rx_byte;
              write_next = 1'b1;
            end
          end
        end else if (sck_fall && (bit_cnt != 3'd0)) begin
          // The fall trailing the previous byte's last bit is skipped so the
          // freshly loaded MSB stays on MISO for the first data rise.
          tx_sr_next = {tx_sr[BYTE_W-2:0], 1'b0};
        end
      end
      COMMIT: begin
        addr_next = next_addr(b_addr_o);
        if (!cs_active) state_next = IDLE;
        else            state_next = rw ? DATA : LOAD;
      end
      default: state_next = IDLE;
    endcase

    // MISO is quiet whenever the chip is deselected.
    if (!cs_active) tx_sr_next = '0;
  end

endmodule
